// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch front-end control stage.
// Digit indices match the counter's adj_sel[1:0] encoding.
package stopwatch_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    localparam logic [1:0] DIG_MIN_L = 2'd0;
    localparam logic [1:0] DIG_MIN_R = 2'd1;
    localparam logic [1:0] DIG_SEC_L = 2'd2;
    localparam logic [1:0] DIG_SEC_R = 2'd3;

    localparam logic [3:0] MAX_ONES     = 4'd9;
    localparam logic [3:0] MAX_SEC_TENS = 4'd5;

    typedef enum logic {
        ST_PAUSED,
        ST_RUNNING
    } run_state_e;

    // Seconds tens only reaches 5; every other digit is a decimal ones-style digit.
    function automatic logic [3:0] clamp_digit(input logic [1:0] sel, input logic [3:0] val);
        logic [3:0] limit;
        limit = (sel == DIG_SEC_L) ? MAX_SEC_TENS : MAX_ONES;
        return (val > limit) ? limit : val;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control bus from the front-end stage to the stopwatch time counter.
// master = control stage (drives), slave = counter (receives).
interface stopwatch_ctrl_if;

    logic       clr;
    logic       paused;
    logic       adj;
    logic [2:0] adj_sel;
    logic [3:0] adj_val;

    modport master (
        output clr,
        output paused,
        output adj,
        output adj_sel,
        output adj_val
    );

    modport slave (
        input clr,
        input paused,
        input adj,
        input adj_sel,
        input adj_val
    );

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioner: two-flop synchronizer, stable-level debounce counter
// and a one-cycle registered pulse on each accepted press (0->1 only).
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int DB_W            = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic            press_q, press_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // The counter measures how long the input has disagreed with the accepted level.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
            press_d  = ~stable_q;
        end else begin
            cnt_d = cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: debounced buttons, synchronized switches, run/pause
// state and clamped adjust-write strobes driving the time counter.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int DB_W            = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_pause,
    input  logic             btn_rst,
    input  logic             btn_load,
    input  logic             sw_adj,
    input  logic [1:0]       sw_sel,
    input  logic [3:0]       sw_val,
    stopwatch_ctrl_if.master cnt_if
);

    logic pause_press, rst_press, load_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_pause (
        .clk(clk), .rst(rst), .btn_i(btn_pause), .press_o(pause_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_rst (
        .clk(clk), .rst(rst), .btn_i(btn_rst), .press_o(rst_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_load (
        .clk(clk), .rst(rst), .btn_i(btn_load), .press_o(load_press)
    );

    // Switch vector layout: {adj, sel[1:0], val[3:0]}
    logic [6:0] sw_s1_q, sw_s2_q;
    run_state_e state_q;
    logic       clr_q, paused_q, adj_q;
    logic [2:0] adj_sel_q;
    logic [3:0] adj_val_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            state_q   <= ST_PAUSED;
            clr_q     <= 1'b0;
            paused_q  <= 1'b1;
            adj_q     <= 1'b0;
            adj_sel_q <= '0;
            adj_val_q <= '0;
        end else begin
            sw_s1_q <= {sw_adj, sw_sel, sw_val};
            sw_s2_q <= sw_s1_q;
            clr_q   <= rst_press;
            adj_q   <= sw_s2_q[6];
            // Adjust mode freezes the run state so leaving it restores the prior state.
            if (pause_press && !adj_q) begin
                state_q <= (state_q == ST_PAUSED) ? ST_RUNNING : ST_PAUSED;
            end
            paused_q <= (state_q == ST_PAUSED) | adj_q;
            if (load_press && adj_q) begin
                adj_sel_q <= {1'b1, sw_s2_q[5:4]};
                adj_val_q <= clamp_digit(sw_s2_q[5:4], sw_s2_q[3:0]);
            end else begin
                adj_sel_q <= '0;
            end
        end
    end

    assign cnt_if.clr     = clr_q;
    assign cnt_if.paused  = paused_q;
    assign cnt_if.adj     = adj_q;
    assign cnt_if.adj_sel = adj_sel_q;
    assign cnt_if.adj_val = adj_val_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a reference model predicts output events
// into a queue, a monitor pops and compares whenever the DUT shows an event.
module tb_stopwatch_ctrl;

    localparam int D = 4;
    localparam int K_CLR = 0, K_STROBE = 1, K_PAUSED = 2, K_ADJ = 3;

    typedef struct {
        int cyc;
        int kind;
        int data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_pause = 1'b0, btn_rst = 1'b0, btn_load = 1'b0, sw_adj = 1'b0;
    logic [1:0] sw_sel = 2'd0;
    logic [3:0] sw_val = 4'd0;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .DB_W(4)) dut (
        .clk(clk), .rst(rst),
        .btn_pause(btn_pause), .btn_rst(btn_rst), .btn_load(btn_load),
        .sw_adj(sw_adj), .sw_sel(sw_sel), .sw_val(sw_val),
        .cnt_if(bus)
    );

    always #5 clk = ~clk;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;

    function automatic int ref_clamp(input int s, input int v);
        int lim;
        lim = (s == 2) ? 5 : 9;
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input int data);
        ev_t e;
        e.cyc = cyc; e.kind = kind; e.data = data;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int data);
        ev_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %0d at cycle %0d, expected no event", kind, data, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data != data) begin
                n_fail++;
                $display("FAIL event: got kind %0d data %0d at cycle %0d, expected kind %0d data %0d at cycle %0d",
                         kind, data, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    // Reference model: inputs are seen two cycles late; a button level is accepted
    // after D consecutive seen cycles of disagreement; consequences are scheduled.
    logic [9:0] h1, h2, seen, raw;
    bit         stable[3];
    int         run[3];
    bit         press[3];
    bit         running;
    int         e_paused, e_adj, e_val;

    task automatic model_reset();
        h1 = '0; h2 = '0;
        for (int b = 0; b < 3; b++) begin stable[b] = 0; run[b] = 0; press[b] = 0; end
        running = 0; e_paused = 1; e_adj = 0; e_val = 0;
        sb.delete();
    endtask

    initial begin
        int n_clr, n_paused, n_adj, n_sel, n_val;
        bit lvl;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                cyc++;
                raw  = {btn_pause, btn_rst, btn_load, sw_adj, sw_sel, sw_val};
                seen = h2; h2 = h1; h1 = raw;
                n_clr    = int'(press[1]);
                n_paused = (!running || e_adj != 0) ? 1 : 0;
                if (press[0] && e_adj == 0) running = !running;
                n_adj = int'(seen[6]);
                if (press[2] && e_adj != 0) begin
                    n_sel = 4 + int'(seen[5:4]);
                    n_val = ref_clamp(int'(seen[5:4]), int'(seen[3:0]));
                end else begin
                    n_sel = 0;
                    n_val = e_val;
                end
                for (int b = 0; b < 3; b++) begin
                    lvl = seen[9-b];
                    press[b] = 0;
                    if (lvl == stable[b]) run[b] = 0;
                    else begin
                        run[b]++;
                        if (run[b] == D) begin
                            stable[b] = lvl; run[b] = 0; press[b] = lvl;
                        end
                    end
                end
                if (n_clr != 0) push_ev(K_CLR, 0);
                if (n_sel != 0) push_ev(K_STROBE, n_sel * 16 + n_val);
                if (n_paused != e_paused) push_ev(K_PAUSED, n_paused);
                if (n_adj != e_adj) push_ev(K_ADJ, n_adj);
                e_paused = n_paused; e_adj = n_adj; e_val = n_val;
            end
        end
    end

    initial begin
        int prev_p, prev_a;
        prev_p = 1; prev_a = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_p = 1; prev_a = 0;
            end else begin
                if (bus.clr) check_ev(K_CLR, 0);
                if (bus.adj_sel[2]) check_ev(K_STROBE, int'(bus.adj_sel) * 16 + int'(bus.adj_val));
                else chk("adj_sel_idle", int'(bus.adj_sel), 0);
                if (int'(bus.paused) != prev_p) check_ev(K_PAUSED, int'(bus.paused));
                if (int'(bus.adj) != prev_a) check_ev(K_ADJ, int'(bus.adj));
                prev_p = int'(bus.paused); prev_a = int'(bus.adj);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_clr"}, int'(bus.clr), 0);
        chk({tag, "_paused"}, int'(bus.paused), 1);
        chk({tag, "_adj"}, int'(bus.adj), 0);
        chk({tag, "_adj_sel"}, int'(bus.adj_sel), 0);
        chk({tag, "_adj_val"}, int'(bus.adj_val), 0);
    endtask

    task automatic press_btn(input int which, input int hold);
        case (which)
            0: btn_pause = 1'b1;
            1: btn_rst   = 1'b1;
            default: btn_load = 1'b1;
        endcase
        step(hold);
        btn_pause = 1'b0; btn_rst = 1'b0; btn_load = 1'b0;
        step(12);
    endtask

    initial begin
        int sels[4] = '{2, 3, 1, 0};
        int vals[4] = '{8, 15, 7, 10};
        bit found;
        step(1);
        // Buttons held through reset release
        btn_pause = 1'b1; btn_rst = 1'b1; btn_load = 1'b1;
        step(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        step(12);
        btn_pause = 1'b0; btn_rst = 1'b0; btn_load = 1'b0;
        step(12);

        // Short glitch, then long hold
        press_btn(0, 3);
        press_btn(0, 10);
        press_btn(0, 10);

        // Clear alone, then clear together with pause
        press_btn(1, 10);
        btn_pause = 1'b1;
        press_btn(1, 10);

        // Adjust writes with clamping
        sw_adj = 1'b1;
        step(6);
        for (int i = 0; i < 4; i++) begin
            sw_sel = 2'(sels[i]); sw_val = 4'(vals[i]);
            step(3);
            press_btn(2, 8);
        end

        // Ignored events
        sw_adj = 1'b0;
        step(6);
        press_btn(2, 8);
        sw_adj = 1'b1;
        step(6);
        press_btn(0, 8);
        sw_adj = 1'b0;
        step(8);

        // Randomized mix
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 7) == 0) sw_adj = ~sw_adj;
            sw_sel    = 2'($urandom_range(0, 3));
            sw_val    = 4'($urandom_range(0, 15));
            btn_pause = ($urandom_range(0, 3) == 0);
            btn_rst   = ($urandom_range(0, 5) == 0);
            btn_load  = ($urandom_range(0, 2) == 0);
            step($urandom_range(1, 10));
        end
        btn_pause = 1'b0; btn_rst = 1'b0; btn_load = 1'b0; sw_adj = 1'b0;
        step(15);

        // Reset during a counting debounce
        btn_pause = 1'b1;
        step(3);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_debounce");
        btn_pause = 1'b0;
        step(2);
        rst = 1'b0;
        step(15);

        // Reset during an adjust strobe
        sw_adj = 1'b1; sw_sel = 2'd3; sw_val = 4'd4;
        step(6);
        btn_load = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.adj_sel[2]) found = 1'b1;
        end
        chk("strobe_seen", int'(found), 1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_strobe");
        btn_load = 1'b0; sw_adj = 1'b0;
        step(3);
        rst = 1'b0;
        step(15);

        chk("events_left", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
